// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART TX sharing logic.
//   DATA_WIDTH  : byte width on the requester / serializer interface
//   WAIT_CYCLES : default idle gap between messages (one bit time)
//   ARB_*       : arbiter state encodings
//   max_int     : helper for sizing counters from two parameters
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_WIDTH  = 8;
   localparam int WAIT_CYCLES = 234;

   localparam logic [1:0] ARB_IDLE   = 2'd0;
   localparam logic [1:0] ARB_STREAM = 2'd1;
   localparam logic [1:0] ARB_GAP    = 2'd2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin select: returns the first set bit of req,
// searching upward from ptr with wrap at N.
//   req   : request vector
//   ptr   : index with highest priority
//   gnt   : one-hot selected request (zero when none)
//   found : at least one request is set
// ----------------------------------------------------------------------------
module rr_picker #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          found
);

   localparam logic [PW:0] N_L = (PW+1)'(N);

   logic [PW:0]   sum;
   logic [PW-1:0] idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         // ptr + k reduced mod N without a divider; one subtract suffices
         // since both operands are below N.
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= N_L) sum = sum - N_L;
         idx = sum[PW-1:0];
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART TX byte serializer between N_REQ requesters. Whole
// messages are granted round-robin; a GAP_CYCLES idle gap follows each
// message, and a message stalled for too long is aborted.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester byte valid
//   req_data   : per-requester byte, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last   : byte is the last of its message
//   req_ready  : byte from requester i accepted this cycle
//   tx_valid / tx_data / tx_ready : valid/ready byte link to the serializer
//   grant      : one-hot current owner (zero outside a message)
//   busy       : arbiter not idle
//   abort      : one-cycle pulse when the watchdog kills a message
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int N_REQ          = 2,
   parameter int DATA_WIDTH     = uart_pkg::DATA_WIDTH,
   parameter int GAP_CYCLES     = uart_pkg::WAIT_CYCLES,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [N_REQ-1:0]            req_last,
   output logic [N_REQ-1:0]            req_ready,
   output logic                        tx_valid,
   output logic [DATA_WIDTH-1:0]       tx_data,
   input  logic                        tx_ready,
   output logic [N_REQ-1:0]            grant,
   output logic                        busy,
   output logic                        abort
);

   import uart_pkg::*;

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(max_int(GAP_CYCLES, TIMEOUT_CYCLES) + 1);

   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
   // The abort decision is taken on the edge where the counter would step
   // to TIMEOUT_CYCLES-1, so the pulse shows TIMEOUT_CYCLES-1 cycles after
   // the last transfer.
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 2);
   localparam logic [PW-1:0] IDX_MAX  = PW'(N_REQ - 1);

   logic [1:0]       state;
   logic [N_REQ-1:0] grant_r;
   logic [PW-1:0]    owner;
   logic [PW-1:0]    rr_ptr;
   logic [CW-1:0]    cnt;
   logic             abort_r;

   logic [N_REQ-1:0] pick_gnt;
   logic             pick_found;
   logic [PW-1:0]    pick_idx;
   logic [PW-1:0]    next_ptr;
   logic             owner_last;
   logic             xfer;

   rr_picker #(.N(N_REQ), .PW(PW)) u_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .gnt   (pick_gnt),
      .found (pick_found)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N_REQ; i++)
         if (pick_gnt[i]) pick_idx = PW'(i);
   end

   // The finishing owner becomes lowest priority on the next pick.
   assign next_ptr = (owner == IDX_MAX) ? '0 : owner + 1'b1;

   // grant_r is only non-zero in STREAM, so gating by it alone keeps the
   // passthrough quiet in IDLE and GAP.
   always_comb begin
      tx_valid   = 1'b0;
      tx_data    = '0;
      owner_last = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_r[i]) begin
            tx_valid   = req_valid[i];
            tx_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            owner_last = req_last[i];
         end
      end
   end

   assign req_ready = grant_r & {N_REQ{tx_ready}};
   assign xfer      = tx_valid & tx_ready;
   assign grant     = grant_r;
   assign busy      = (state != ARB_IDLE);
   assign abort     = abort_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ARB_IDLE;
         grant_r <= '0;
         owner   <= '0;
         rr_ptr  <= '0;
         cnt     <= '0;
         abort_r <= 1'b0;
      end else begin
         abort_r <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (pick_found) begin
                  grant_r <= pick_gnt;
                  owner   <= pick_idx;
                  cnt     <= '0;
                  state   <= ARB_STREAM;
               end
            end
            ARB_STREAM: begin
               if (xfer) begin
                  cnt <= '0;
                  if (owner_last) begin
                     grant_r <= '0;
                     rr_ptr  <= next_ptr;
                     state   <= ARB_GAP;
                  end
               end else if (!tx_valid) begin
                  // Only an absent byte counts toward the watchdog;
                  // serializer backpressure holds the counter.
                  if (cnt == TO_LAST) begin
                     abort_r <= 1'b1;
                     grant_r <= '0;
                     rr_ptr  <= next_ptr;
                     cnt     <= '0;
                     state   <= ARB_GAP;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ARB_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  state <= ARB_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state   <= ARB_IDLE;
               grant_r <= '0;
               cnt     <= '0;
            end
         endcase
      end
   end

endmodule
